seq_match_stats: RTL and testbench
==================================

Name: seq_match_stats

Overview:
- Downstream consumer of the two-consecutive-equal-bit sequence recognizer. Takes that recognizer's 1-bit match flag as `match_in`.
- Over a fixed measurement window of WINDOW clock cycles it collects two statistics:
  - the number of match events (rising edges of `match_in`);
  - the longest continuous run of `match_in` high.
- Results are published through a valid/ready handshake to the next stage, for example a status register or a logger.

Parameters:
- WINDOW, 16: number of `match_in` samples per measurement; legal range is 1 and up.
- CNT_W, 8: width of `event_count` and `max_run`. Both counters saturate at 2^CNT_W-1.

Ports:
- clock: input, 1 bit. Single clock; all logic acts on its rising edge.
- reset: input, 1 bit. Synchronous, active-high reset.
- match_in: input, 1 bit. Match flag from the sequence recognizer, sampled every clock while measuring.
- start: input, 1 bit. Request to begin a measurement window.
- busy: output, 1 bit. High while in ACCUM.
- result_valid: output, 1 bit. High while a result is held.
- result_ready: input, 1 bit. Downstream accepts the result.
- event_count: output, CNT_W bits. Number of 0-to-1 transitions of `match_in` in the window.
- max_run: output, CNT_W bits. Longest run of consecutive samples with `match_in` high.

Behaviour:
- Reset:
  - Synchronous to `clock`, active-high, highest priority, effective in any state.
  - After the reset edge: state is IDLE and `busy`, `result_valid`, `event_count`, `max_run` are all 0.
  - Internal `prev_match`, the window counter, `cur_run` and `cur_events` are all 0.
- State IDLE:
  - `busy`=0, `result_valid`=0.
  - `start`=1 at edge t0 moves to ACCUM. The same edge clears `cur_events`, `cur_run`, the running maximum, the window counter and `prev_match`.
- State ACCUM:
  - `busy`=1. `match_in` is sampled at edges t0+1 through t0+WINDOW, exactly WINDOW samples.
  - Per sample:
    - If `match_in`=1 and `prev_match`=0, increment `cur_events`.
    - If `match_in`=1, increment `cur_run`; otherwise clear `cur_run` to 0.
    - Update the running max with max(running max, updated `cur_run`).
    - Set `prev_match` to `match_in`.
  - `prev_match` starts at 0, so `match_in`=1 on the first sample counts as an event.
  - All counters saturate at 2^CNT_W-1 and never wrap.
  - On the WINDOW-th sample (edge t0+WINDOW):
    - Load `event_count` and `max_run` with the values updated to include that final sample.
    - Move to DONE.
    - A run still open at the window end is included in `max_run`.
  - `start` is ignored in ACCUM; there is no restart.
  - The window counter width is ceil(log2(WINDOW+1)).
- State DONE:
  - `result_valid`=1 and `busy`=0.
  - `event_count` and `max_run` stay stable until accepted.
  - `match_in` is ignored.
  - `result_ready`=1 at an edge completes the handshake:
    - With `start`=0, go to IDLE; `result_valid` is 0 after that edge.
    - With `start`=1 in the same cycle, go directly to ACCUM with counters cleared, as in IDLE. That edge is t0 of the new window.
  - `start` without `result_ready` is ignored.
  - `event_count` and `max_run` keep their last result in IDLE and ACCUM. They change only at the WINDOW-th sample or on reset.
- Latency:
  - `start` at edge t0 gives `result_valid` high after edge t0+WINDOW.
  - Back-to-back windows with `result_ready` held high cost WINDOW+1 cycles per result.
- Reset mid-operation:
  - In ACCUM or DONE, reset discards partial or pending results and returns to IDLE with all outputs 0.

Test Plan:
1. Assert reset for 2 cycles, then release -> `busy`=0, `result_valid`=0, `event_count`=0, `max_run`=0. A later `start` works normally.
2. WINDOW=16, `match_in`=0,1,1,0,1,1,1,0,0,1,0,0,0,0,0,0 with `result_ready`=1 -> `result_valid` 16 cycles after `start`, `event_count`=3, `max_run`=3, back to IDLE next cycle.
3. `match_in` held 1 for the whole window -> `event_count`=1, `max_run`=16. Alternating 1,0,... -> `event_count`=8, `max_run`=1.
4. Backpressure: `result_ready`=0 for 5 cycles in DONE, with `match_in` toggling and `start` pulsed -> `result_valid` held, values unchanged, no new window. Then `result_ready`=1 with `start`=1 -> `busy`=1 next cycle and a new result after 16 more samples.
5. Saturation with CNT_W=3, WINDOW=16, all ones -> `max_run`=7, `event_count`=1.
6. Reset asserted at sample 9 of ACCUM -> IDLE with outputs 0. A fresh `start` collects a full 16-sample window unaffected by the earlier samples.

Source files
------------

// File: rtl/seq_match_stats.sv
// Match-flag statistics over a fixed window: rising-edge count and
// longest high run, published to the next stage by valid/ready.
module seq_match_stats #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             match_in,
    input  logic             start,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] event_count,
    output logic [CNT_W-1:0] max_run
);

    localparam int WC_W = $clog2(WINDOW + 1);
    localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              prev_q, prev_d;
    logic [WC_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]  cur_run_q, cur_run_d;
    logic [CNT_W-1:0]  cur_events_q, cur_events_d;
    logic [CNT_W-1:0]  run_max_q, run_max_d;
    logic [CNT_W-1:0]  event_count_q, event_count_d;
    logic [CNT_W-1:0]  max_run_q, max_run_d;

    logic [CNT_W-1:0]  run_nxt;
    logic [CNT_W-1:0]  events_nxt;
    logic [CNT_W-1:0]  max_nxt;

    // Per-sample updates, saturating at the counter ceiling
    always_comb begin
        run_nxt    = '0;
        events_nxt = cur_events_q;
        if (match_in) begin
            run_nxt = (cur_run_q == CNT_MAX) ? CNT_MAX : cur_run_q + 1'b1;
            if (!prev_q && cur_events_q != CNT_MAX) begin
                events_nxt = cur_events_q + 1'b1;
            end
        end
        max_nxt = (run_nxt > run_max_q) ? run_nxt : run_max_q;
    end

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        win_d         = win_q;
        cur_run_d     = cur_run_q;
        cur_events_d  = cur_events_q;
        run_max_d     = run_max_q;
        event_count_d = event_count_q;
        max_run_d     = max_run_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = ACCUM;
                    prev_d       = 1'b0;
                    win_d        = '0;
                    cur_run_d    = '0;
                    cur_events_d = '0;
                    run_max_d    = '0;
                end
            end
            ACCUM: begin
                prev_d       = match_in;
                win_d        = win_q + 1'b1;
                cur_run_d    = run_nxt;
                cur_events_d = events_nxt;
                run_max_d    = max_nxt;
                if (win_q == WIN_LAST) begin
                    state_d       = DONE;
                    event_count_d = events_nxt;
                    max_run_d     = max_nxt;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                    if (start) begin
                        state_d      = ACCUM;
                        prev_d       = 1'b0;
                        win_d        = '0;
                        cur_run_d    = '0;
                        cur_events_d = '0;
                        run_max_d    = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            prev_q        <= 1'b0;
            win_q         <= '0;
            cur_run_q     <= '0;
            cur_events_q  <= '0;
            run_max_q     <= '0;
            event_count_q <= '0;
            max_run_q     <= '0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            win_q         <= win_d;
            cur_run_q     <= cur_run_d;
            cur_events_q  <= cur_events_d;
            run_max_q     <= run_max_d;
            event_count_q <= event_count_d;
            max_run_q     <= max_run_d;
        end
    end

    assign busy         = (state_q == ACCUM);
    assign result_valid = (state_q == DONE);
    assign event_count  = event_count_q;
    assign max_run      = max_run_q;

endmodule

// File: tb/tb_seq_match_stats.sv
// Randomized bench for seq_match_stats: a wide and a 3-bit instance
// share stimulus and are checked against a window-level model.
module tb_seq_match_stats;

    logic       clock = 1'b0;
    logic       reset;
    logic       match_in;
    logic       start;
    logic       result_ready;
    logic       busy_a, valid_a;
    logic [7:0] ev_a, mr_a;
    logic       busy_b, valid_b;
    logic [2:0] ev_b, mr_b;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_ev_a = 0, exp_mr_a = 0;
    int exp_ev_b = 0, exp_mr_b = 0;

    always #5 clock = ~clock;

    seq_match_stats #(.WINDOW(16), .CNT_W(8)) dut_a (
        .clock(clock), .reset(reset), .match_in(match_in),
        .start(start), .busy(busy_a), .result_valid(valid_a),
        .result_ready(result_ready), .event_count(ev_a),
        .max_run(mr_a)
    );

    seq_match_stats #(.WINDOW(16), .CNT_W(3)) dut_b (
        .clock(clock), .reset(reset), .match_in(match_in),
        .start(start), .busy(busy_b), .result_valid(valid_b),
        .result_ready(result_ready), .event_count(ev_b),
        .max_run(mr_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // Window statistics straight from the definition
    task automatic model(input logic [15:0] pat);
        int ev, mr, run;
        ev = 0; mr = 0; run = 0;
        for (int i = 0; i < 16; i++) begin
            if (pat[i] && (i == 0 || !pat[i-1])) ev++;
            run = pat[i] ? run + 1 : 0;
            if (run > mr) mr = run;
        end
        exp_ev_a = sat(ev, 8); exp_mr_a = sat(mr, 8);
        exp_ev_b = sat(ev, 3); exp_mr_b = sat(mr, 3);
    endtask

    task automatic check_all(input string tag, input int b, input int v);
        chk({tag, ".busy"},    busy_a,  b);
        chk({tag, ".valid"},   valid_a, v);
        chk({tag, ".events"},  ev_a,    exp_ev_a);
        chk({tag, ".maxrun"},  mr_a,    exp_mr_a);
        chk({tag, ".busy3"},   busy_b,  b);
        chk({tag, ".valid3"},  valid_b, v);
        chk({tag, ".events3"}, ev_b,    exp_ev_b);
        chk({tag, ".maxrun3"}, mr_b,    exp_mr_b);
    endtask

    task automatic begin_from_idle();
        start    = 1'b1;
        match_in = 1'($urandom);
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called just after edge t0; ends just after edge t0+16
    task automatic feed(input string tag, input logic [15:0] pat);
        for (int i = 0; i < 16; i++) begin
            check_all({tag, ".accum"}, 1, 0);
            match_in     = pat[i];
            start        = 1'($urandom);
            result_ready = 1'($urandom);
            @(negedge clock);
        end
        start        = 1'b0;
        result_ready = 1'b0;
        model(pat);
        check_all({tag, ".done"}, 0, 1);
    endtask

    task automatic release_result(input string tag, input int delay);
        for (int i = 0; i < delay; i++) begin
            result_ready = 1'b0;
            start        = 1'($urandom);
            match_in     = 1'($urandom);
            @(negedge clock);
            check_all({tag, ".hold"}, 0, 1);
        end
        result_ready = 1'b1;
        start        = 1'b0;
        @(negedge clock);
        result_ready = 1'b0;
        check_all({tag, ".idle"}, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pat;
        reset = 1'b1; start = 1'b0; match_in = 1'b0; result_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_all("reset", 0, 0);

        begin_from_idle();
        feed("mixed", 16'h0276);
        chk("mixed.ev_abs", ev_a, 3);
        chk("mixed.mr_abs", mr_a, 3);
        release_result("mixed", 0);

        begin_from_idle();
        feed("ones", 16'hFFFF);
        chk("ones.mr_abs", mr_a, 16);
        chk("ones.mr3_abs", mr_b, 7);
        chk("ones.ev3_abs", ev_b, 1);
        release_result("ones", 1);

        begin_from_idle();
        feed("alt", 16'h5555);
        chk("alt.ev_abs", ev_a, 8);
        chk("alt.mr_abs", mr_a, 1);

        // Backpressure, then accept and restart in the same cycle
        for (int i = 0; i < 5; i++) begin
            result_ready = 1'b0;
            start        = (i == 2);
            match_in     = 1'($urandom);
            @(negedge clock);
            check_all("bp.hold", 0, 1);
        end
        result_ready = 1'b1;
        start        = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
        start        = 1'b0;
        feed("bp.next", 16'h0F0F);
        release_result("bp.next", 0);

        // Reset while the ninth sample is presented
        begin_from_idle();
        for (int i = 0; i < 8; i++) begin
            match_in = 1'b1;
            @(negedge clock);
        end
        reset    = 1'b1;
        match_in = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_ev_a = 0; exp_mr_a = 0; exp_ev_b = 0; exp_mr_b = 0;
        check_all("midrst", 0, 0);
        begin_from_idle();
        feed("midrst.fresh", 16'h8001);
        release_result("midrst.fresh", 2);

        for (int w = 0; w < 20; w++) begin
            pat = 16'($urandom);
            begin_from_idle();
            feed("rand", pat);
            release_result("rand", int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
